// File: rtl/fetch_stage.sv
// fetch_stage -- Instruction Fetch (F) stage of the P7 five-stage MIPS pipeline.
//
// Holds the architectural fetch PC and picks the next PC from exception
// entry, eret return, stall hold, D-stage redirect or sequential PC+4.
// Each fetch is screened for address errors (AdEL). The outputs feed the
// F/D pipeline register.
//
// Ports:
//   clk         system clock, rising-edge active
//   reset       asynchronous, active-high reset
//   en          1 = advance, 0 = hold PC (D-stage stall)
//   req         exception/interrupt taken; next PC = EXC_ENTRY
//   eret_D      eret in D; next PC = epc, wrong-path fetch squashed
//   epc         CP0 EPC (eret return target)
//   redirect_D  taken branch/jump resolved in D
//   target_D    branch/jump target from D
//   branch_D    instruction in D has a delay slot
//   im_rdata    instruction word from combinational instruction memory
//   im_addr     instruction-memory byte address (= pc_F)
//   pc_F        current fetch PC
//   instr_F     fetched instruction, or 0 when suppressed
//   excCode_F   5'd4 (AdEL) on a bad fetch, else 0
//   BD_F        fetched instruction sits in a branch delay slot
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        req,
    input  logic        eret_D,
    input  logic [31:0] epc,
    input  logic        redirect_D,
    input  logic [31:0] target_D,
    input  logic        branch_D,
    input  logic [31:0] im_rdata,
    output logic [31:0] im_addr,
    output logic [31:0] pc_F,
    output logic [31:0] instr_F,
    output logic [4:0]  excCode_F,
    output logic        BD_F
);

    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        adel;
    logic        squash;

    // Next-PC selection in strict priority order. req and eret override a
    // stall because both abandon the current instruction stream.
    always_comb begin
        // NOTE: pc_next gets a default before the if-chain so every path
        // assigns it; otherwise synthesis infers a latch.
        pc_next = pc_q + 32'd4;
        if (req)             pc_next = EXC_ENTRY;
        else if (eret_D)     pc_next = epc;
        else if (!en)        pc_next = pc_q;
        else if (redirect_D) pc_next = target_D;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples its inputs from before the clock edge.
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_next;
    end

    // Misaligned or outside the instruction-memory window.
    assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);

    // eret has no delay slot: whatever is being fetched alongside it is
    // wrong-path. While reset is held the fetch passes straight through.
    assign squash = eret_D && !reset;

    assign pc_F      = pc_q;
    assign im_addr   = pc_q;
    assign instr_F   = (squash || adel) ? 32'h0 : im_rdata;
    assign excCode_F = (!squash && adel) ? EXC_ADEL : 5'd0;
    assign BD_F      = branch_D && !eret_D;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with hand-computed expected values.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        req;
    logic        eret_D;
    logic [31:0] epc;
    logic        redirect_D;
    logic [31:0] target_D;
    logic        branch_D;
    logic [31:0] im_rdata;
    logic [31:0] im_addr;
    logic [31:0] pc_F;
    logic [31:0] instr_F;
    logic [4:0]  excCode_F;
    logic        BD_F;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] WORD = 32'hDEAD_BEEF;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .req        (req),
        .eret_D     (eret_D),
        .epc        (epc),
        .redirect_D (redirect_D),
        .target_D   (target_D),
        .branch_D   (branch_D),
        .im_rdata   (im_rdata),
        .im_addr    (im_addr),
        .pc_F       (pc_F),
        .instr_F    (instr_F),
        .excCode_F  (excCode_F),
        .BD_F       (BD_F)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle redirect to addr, then drop the redirect.
    task automatic jump(input logic [31:0] addr);
        redirect_D = 1'b1;
        target_D   = addr;
        en         = 1'b1;
        step();
        redirect_D = 1'b0;
        #1;
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b1; req = 1'b0; eret_D = 1'b0; epc = 32'h0;
        redirect_D = 1'b0; target_D = 32'h0; branch_D = 1'b1; im_rdata = WORD;
        #1;
        check("rst_pc",     pc_F, 32'h3000);
        check("rst_imaddr", im_addr, 32'h3000);
        check("rst_exc",    {27'b0, excCode_F}, 32'd0);
        check("rst_instr",  instr_F, WORD);
        check("rst_bd",     {31'b0, BD_F}, 32'd1);
        branch_D = 1'b0;
        #1 reset = 1'b0;          // released before the first edge at t=5
        #1;
        check("seq0", pc_F, 32'h3000);
        step(); check("seq1", pc_F, 32'h3004); check("seq1_exc", {27'b0, excCode_F}, 32'd0);
        step(); check("seq2", pc_F, 32'h3008); check("seq2_exc", {27'b0, excCode_F}, 32'd0);
        step(); check("seq3", pc_F, 32'h300C); check("seq3_exc", {27'b0, excCode_F}, 32'd0);
        step(); check("seq4", pc_F, 32'h3010);

        // Taken branch from D: BD_F now, target next cycle.
        redirect_D = 1'b1; target_D = 32'h3100; branch_D = 1'b1;
        #1 check("br_bd", {31'b0, BD_F}, 32'd1);
        step(); check("br_pc", pc_F, 32'h3100);
        branch_D = 1'b0;

        // Same redirect while stalled: PC holds.
        jump(32'h3010);
        check("back_pc", pc_F, 32'h3010);
        redirect_D = 1'b1; target_D = 32'h3100; en = 1'b0;
        step(); check("stall_pc", pc_F, 32'h3010);
        redirect_D = 1'b0; en = 1'b1;

        // Address-error boundaries.
        jump(32'h3102);
        check("mis_exc", {27'b0, excCode_F}, 32'd4); check("mis_instr", instr_F, 32'h0);
        jump(32'h7000);
        check("hi_exc", {27'b0, excCode_F}, 32'd4);  check("hi_instr", instr_F, 32'h0);
        jump(32'h2FFC);
        check("lo_exc", {27'b0, excCode_F}, 32'd4);  check("lo_instr", instr_F, 32'h0);
        jump(32'h6FFC);
        check("lim_exc", {27'b0, excCode_F}, 32'd0); check("lim_instr", instr_F, WORD);
        check("lim_imaddr", im_addr, 32'h6FFC);
        step(); check("wrap_pc", pc_F, 32'h7000); check("wrap_exc", {27'b0, excCode_F}, 32'd4);

        // Exception request overrides a stall.
        jump(32'h3020);
        req = 1'b1; en = 1'b0;
        step(); check("req_pc", pc_F, 32'h4180);
        req = 1'b0; en = 1'b1;

        // req beats eret.
        jump(32'h3020);
        req = 1'b1; eret_D = 1'b1; epc = 32'h3040;
        step(); check("req_eret_pc", pc_F, 32'h4180);
        req = 1'b0; eret_D = 1'b0;

        // eret: squash in-flight fetch, return to EPC next cycle.
        eret_D = 1'b1; epc = 32'h3040; branch_D = 1'b1;
        #1;
        check("eret_instr", instr_F, 32'h0);
        check("eret_bd",    {31'b0, BD_F}, 32'd0);
        check("eret_exc",   {27'b0, excCode_F}, 32'd0);
        step(); check("eret_pc", pc_F, 32'h3040);
        eret_D = 1'b0; branch_D = 1'b0;

        // Asynchronous reset mid-cycle with a redirect pending.
        jump(32'h3200);
        check("pre_rst_pc", pc_F, 32'h3200);
        redirect_D = 1'b1; target_D = 32'h3400;
        #2 reset = 1'b1;
        #1 check("async_rst_pc", pc_F, 32'h3000);
        step(); check("rst_hold_pc", pc_F, 32'h3000);
        redirect_D = 1'b0;
        #1 reset = 1'b0;
        #1 check("rst_rel_pc", pc_F, 32'h3000);
        step(); check("resume_pc", pc_F, 32'h3004);
        step(); check("resume_pc2", pc_F, 32'h3008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
